// File: rtl/esfa_op_sequencer.sv
// ESFA operation sequencer: turns one command into a short train of
// array steps (issue, sample) and returns the final step's result.
module esfa_op_sequencer #(
    parameter logic [7:0] SEL_IDLE   = 8'd0,
    parameter logic [7:0] SEL_LOOKUP = 8'd1,
    parameter logic [7:0] SEL_ALLOC  = 8'd5,
    parameter logic [7:0] SEL_WRITE  = 8'd3,
    parameter logic [7:0] SEL_CODE   = 8'd2,
    parameter logic [7:0] SEL_RANK   = 8'd6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_handle,
    input  logic [7:0] cmd_index,
    input  logic [7:0] cmd_value,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_bool,
    output logic [7:0] rsp_value,
    output logic       rsp_err,
    output logic [7:0] arr_sel,
    output logic [7:0] arr_handle,
    output logic [7:0] arr_index,
    output logic [7:0] arr_value,
    input  logic       arr_result_bool,
    input  logic [7:0] arr_result_value,
    output logic       busy,
    output logic [7:0] done_count
);

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_RERANK = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SAMPLE,
        S_RESP
    } state_t;

    state_t     state;
    logic [1:0] op_q;
    logic [1:0] step;
    logic [1:0] step_nxt;

    // Array selector for a given op at a given step index
    function automatic logic [7:0] sel_of(
        input logic [1:0] op,
        input logic [1:0] stp
    );
        logic [7:0] s;
        s = SEL_IDLE;
        case (op)
            OP_LOOKUP: s = SEL_LOOKUP;
            OP_INSERT: s = (stp == 2'd0) ? SEL_ALLOC : SEL_WRITE;
            OP_RERANK: s = (stp == 2'd0) ? SEL_CODE : SEL_RANK;
            default:   s = SEL_IDLE;
        endcase
        return s;
    endfunction

    // Number of array steps an op takes
    function automatic logic [1:0] steps_of(input logic [1:0] op);
        return (op == OP_LOOKUP) ? 2'd1 : 2'd2;
    endfunction

    assign step_nxt  = step + 2'd1;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Sequencer FSM with registered array drives and response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_q       <= 2'd0;
            step       <= 2'd0;
            arr_sel    <= SEL_IDLE;
            arr_handle <= 8'd0;
            arr_index  <= 8'd0;
            arr_value  <= 8'd0;
            rsp_valid  <= 1'b0;
            rsp_bool   <= 1'b0;
            rsp_value  <= 8'd0;
            rsp_err    <= 1'b0;
            done_count <= 8'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        step       <= 2'd0;
                        arr_handle <= cmd_handle;
                        arr_index  <= cmd_index;
                        arr_value  <= cmd_value;
                        rsp_bool   <= 1'b0;
                        rsp_value  <= 8'd0;
                        if (cmd_op == OP_RSVD) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state   <= S_ISSUE;
                            arr_sel <= sel_of(cmd_op, 2'd0);
                            rsp_err <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    arr_sel <= SEL_IDLE;
                    state   <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    rsp_bool  <= arr_result_bool;
                    rsp_value <= arr_result_value;
                    step      <= step_nxt;
                    if (step_nxt < steps_of(op_q)) begin
                        state   <= S_ISSUE;
                        arr_sel <= sel_of(op_q, step_nxt);
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        done_count <= done_count + 8'd1;
                        state      <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/esfa_op_sequencer.md
ESFA_OP_SEQUENCER -- requirements
Module: esfa_op_sequencer

Interface
REQ-001 SHALL provide parameter SEL_IDLE, default 8'd0, array selector driven when no step is issued.
REQ-002 SHALL provide parameter SEL_LOOKUP, default 8'd1, lookup step selector.
REQ-003 SHALL provide parameters SEL_ALLOC 8'd5, SEL_WRITE 8'd3, SEL_CODE 8'd2, SEL_RANK 8'd6, the insert and rerank step selectors.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_op in 2, cmd_handle in 8, cmd_index in 8, cmd_value in 8: command channel.
REQ-007 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_bool out 1, rsp_value out 8, rsp_err out 1: response channel.
REQ-008 SHALL have arr_sel out 8, arr_handle out 8, arr_index out 8, arr_value out 8: drives to the ESFA cell array.
REQ-009 SHALL have arr_result_bool in 1, arr_result_value in 8: combined array result.
REQ-010 SHALL have busy out 1 and done_count out 8: status.

Function
REQ-011 SHALL implement states IDLE, ISSUE, SAMPLE, RESP; encoding free.
REQ-012 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready on a rising edge.
REQ-013 On accept, SHALL register cmd_op/handle/index/value into arr_handle/arr_index/arr_value and hold them unchanged until return to IDLE.
REQ-014 Op decode: 0 LOOKUP = 1 step {SEL_LOOKUP}; 1 INSERT = 2 steps {SEL_ALLOC, SEL_WRITE}; 2 RERANK = 2 steps {SEL_CODE, SEL_RANK}; 3 reserved.
REQ-015 Op 3 SHALL go IDLE->RESP with rsp_err=1, rsp_bool=0, rsp_value=0, no ISSUE cycle, arr_sel stays SEL_IDLE.
REQ-016 ISSUE (exactly 1 cycle) SHALL drive registered arr_sel = current step selector; all other states drive SEL_IDLE.
REQ-017 SAMPLE (exactly 1 cycle) SHALL capture arr_result_bool/value into rsp_bool/rsp_value on its closing edge; then ISSUE if steps remain, else RESP.
REQ-018 A 2-bit step counter SHALL clear on accept and increment on each SAMPLE; response reflects final step only.
REQ-019 Latency from accept edge T: LOOKUP rsp_valid=1 in cycle T+3; INSERT/RERANK in T+5; reserved in T+1.
REQ-020 RESP SHALL hold rsp_valid=1 and stable rsp_* until rsp_valid & rsp_ready, then IDLE next cycle; rsp_valid=0 elsewhere.
REQ-021 No command SHALL be accepted while in ISSUE, SAMPLE or RESP, including the response-handshake cycle.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 done_count SHALL increment by 1 on each response handshake (including errors), wrapping 255->0.
REQ-024 rsp_ready asserted outside RESP SHALL have no effect; cmd_* changes outside IDLE SHALL have no effect.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) force IDLE, arr_sel=SEL_IDLE, arr_handle/index/value=0, rsp_valid=0, rsp_bool=0, rsp_value=0, rsp_err=0, step=0, done_count=0, busy=0.
REQ-026 Reset asserted mid-operation SHALL abandon it with no response; after release first accept is possible on the first rising edge with reset=1.

Verification
REQ-027 LOOKUP op=0 handle=3 index=7, array returns bool=1 value=8'h2A at SAMPLE -> arr_sel=1 for one cycle at T+1, rsp_valid at T+3 with bool=1 value=8'h2A err=0.
REQ-028 INSERT op=1 value=8'h55 -> arr_sel sequence 5,0,3,0 over T+1..T+4; rsp_value equals result sampled after SEL_WRITE; rsp_valid at T+5.
REQ-029 Reserved op=3 -> rsp_valid at T+1, err=1, arr_sel never leaves 0, done_count +1.
REQ-030 rsp_ready held 0 for 10 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0 throughout; next command accepted only after handshake.
REQ-031 Assert reset during INSERT second ISSUE -> arr_sel=0 and all outputs at reset values immediately, no rsp_valid afterwards.
REQ-032 256 back-to-back LOOKUPs -> done_count returns to 0; rsp ordering matches command order.
